fir: RTL and testbench



---
 rtl/fir_pkg.sv | 10 +
 rtl/fir_tap.sv | 27 ++
 rtl/fir.sv | 81 ++++++++
 tb/tb_fir.sv | 130 +++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared defaults for the direct-form FIR: the band-edge receive filter geometry.
package fir_pkg;

    localparam int DEFAULT_INPUT_BITS       = 12;
    localparam int DEFAULT_COEFF_BITS       = 14;
    localparam int DEFAULT_ACC_BITS         = 27;
    localparam int DEFAULT_NUM_TAPS         = 21;
    localparam int DEFAULT_TRUNCATION_BITS  = 14;

endpackage

// File: rtl/fir_tap.sv
// One FIR tap: a delay-line register and its signed coefficient product.
module fir_tap
    import fir_pkg::*;
#(
    parameter int InputLengthBits       = DEFAULT_INPUT_BITS,
    parameter int CoefficientLengthBits = DEFAULT_COEFF_BITS,
    parameter logic signed [CoefficientLengthBits-1:0] Coefficient = '0
) (
    input  logic                                                   clk,
    input  logic                                                   rst,
    input  logic signed [InputLengthBits-1:0]                      sample,
    output logic signed [InputLengthBits-1:0]                      x,
    output logic signed [InputLengthBits+CoefficientLengthBits-1:0] prod
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            x <= '0;
        end else begin
            x <= sample;
        end
    end

    // Both operands signed, so they are sign-extended to the full product width.
    assign prod = x * Coefficient;

endmodule

// File: rtl/fir.sv
// Fully parallel direct-form FIR; accumulator is floored by an arithmetic shift
// and clamped back to the sample width.
module fir
    import fir_pkg::*;
#(
    parameter int InputLengthBits       = DEFAULT_INPUT_BITS,
    parameter int CoefficientLengthBits = DEFAULT_COEFF_BITS,
    parameter int AccumulatorLengthBits = DEFAULT_ACC_BITS,
    parameter int NumTaps               = DEFAULT_NUM_TAPS,
    parameter int OutputTruncationBits  = DEFAULT_TRUNCATION_BITS,
    parameter logic [NumTaps*CoefficientLengthBits-1:0] Coefficients = '0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic signed [InputLengthBits-1:0] in,
    output logic signed [InputLengthBits-1:0] out
);

    localparam int IW = InputLengthBits;
    localparam int CW = CoefficientLengthBits;
    localparam int AW = AccumulatorLengthBits;
    localparam int PW = InputLengthBits + CoefficientLengthBits;

    localparam longint OutMaxVal = (longint'(1) <<< (IW - 1)) - longint'(1);
    localparam longint OutMinVal = -(longint'(1) <<< (IW - 1));
    localparam logic signed [AW-1:0] OUT_MAX = AW'(OutMaxVal);
    localparam logic signed [AW-1:0] OUT_MIN = AW'(OutMinVal);

    logic signed [IW-1:0] tap_x [NumTaps];
    logic signed [PW-1:0] prod  [NumTaps];
    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] shifted;
    logic signed [IW-1:0] sat_val;

    // Tap 0 takes the most-significant coefficient field and the newest sample.
    for (genvar k = 0; k < NumTaps; k++) begin : g_tap
        logic signed [IW-1:0] sample;

        if (k == 0) begin : g_first
            assign sample = in;
        end else begin : g_chain
            assign sample = tap_x[k-1];
        end

        fir_tap #(
            .InputLengthBits      (IW),
            .CoefficientLengthBits(CW),
            .Coefficient          (Coefficients[(NumTaps-1-k)*CW +: CW])
        ) u_tap (
            .clk   (clk),
            .rst   (rst),
            .sample(sample),
            .x     (tap_x[k]),
            .prod  (prod[k])
        );
    end

    always_comb begin
        acc = '0;
        for (int k = 0; k < NumTaps; k++) begin
            acc = acc + AW'(prod[k]);
        end
        shifted = acc >>> OutputTruncationBits;
        if (shifted > OUT_MAX) begin
            sat_val = OUT_MAX[IW-1:0];
        end else if (shifted < OUT_MIN) begin
            sat_val = OUT_MIN[IW-1:0];
        end else begin
            sat_val = shifted[IW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out <= '0;
        end else begin
            out <= sat_val;
        end
    end

endmodule

// File: tb/tb_fir.sv
// Scoreboard bench for the 21-tap band-edge FIR configuration.
module tb_fir;

    localparam int NT = 21;
    localparam int CW = 14;

    localparam int TAPS [NT] = '{-61, 63, 173, 63, -307, -642, -434, 642, 2371, 3994, 4658,
                                 3994, 2371, 642, -434, -642, -307, 63, 173, 63, -61};

    localparam int IMPULSE [NT] = '{-8, 7, 21, 7, -39, -81, -55, 80, 296, 499, 581,
                                    499, 296, 80, -55, -81, -39, 7, 21, 7, -8};

    function automatic logic [NT*CW-1:0] pack_coeffs();
        logic [NT*CW-1:0] r;
        r = '0;
        for (int k = 0; k < NT; k++) begin
            r[(NT-1-k)*CW +: CW] = CW'(TAPS[k]);
        end
        return r;
    endfunction

    localparam logic [NT*CW-1:0] COEFFS = pack_coeffs();

    typedef struct {
        bit                 chk;
        logic signed [11:0] val;
        string              name;
    } exp_t;

    logic               clk;
    logic               rst;
    logic signed [11:0] in_s;
    logic signed [11:0] out_s;

    exp_t exp_q [$];
    int   n_total = 0;
    int   n_pass  = 0;

    fir #(
        .InputLengthBits      (12),
        .CoefficientLengthBits(CW),
        .AccumulatorLengthBits(27),
        .NumTaps              (NT),
        .OutputTruncationBits (14),
        .Coefficients         (COEFFS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in (in_s),
        .out(out_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Each step drives one cycle and queues the value out must hold after that edge.
    task automatic step(input logic r, input int v, input bit chk, input int ev, input string nm);
        exp_t e;
        @(negedge clk);
        rst  = r;
        in_s = 12'(v);
        e.chk  = chk;
        e.val  = 12'(ev);
        e.name = nm;
        exp_q.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.chk) begin
                    n_total++;
                    if (out_s === e.val) begin
                        n_pass++;
                    end else begin
                        $display("FAIL %s: out=%0d expected=%0d", e.name, out_s, e.val);
                    end
                end
            end
        end
    end

    initial begin
        rst  = 1'b0;
        in_s = 12'h000;

        for (int i = 0; i < 500; i++) step(1'b0, 12'hAAA, 1'b1, 0, "reset_hold");
        for (int i = 0; i < 500; i++) step(1'b1, 0, 1'b1, 0, "zero_input");

        step(1'b1, 2047, 1'b1, 0, "impulse_edge");
        for (int i = 0; i < NT; i++) step(1'b1, 0, 1'b1, IMPULSE[i], "impulse_resp");
        for (int i = 0; i < 3; i++) step(1'b1, 0, 1'b1, 0, "impulse_tail");

        for (int i = 1; i <= 30; i++) step(1'b1, 1000, i >= 22, 999, "dc_1000");
        for (int i = 1; i <= 30; i++) step(1'b1, 2047, i >= 22, 2046, "dc_2047");

        for (int i = 1; i <= 25; i++) step(1'b1, 1000, i >= 22, 999, "dc_pre_reset");
        step(1'b0, 1000, 1'b1, 0, "mid_reset");
        step(1'b1, 1000, 1'b1, 0, "reramp_1");
        step(1'b1, 1000, 1'b1, -4, "reramp_2");
        step(1'b1, 1000, 1'b1, 0, "reramp_3");
        step(1'b1, 1000, 1'b1, 10, "reramp_4");
        for (int i = 5; i <= 26; i++) step(1'b1, 1000, i >= 22, 999, "reramp_settle");

        // Oldest sample first, so after NT edges x[k] carries the sign of c[k].
        for (int j = 0; j < NT; j++)
            step(1'b1, (TAPS[NT-1-j] > 0) ? 2047 : -2047, 1'b0, 0, "sat_pos_fill");
        for (int j = 0; j < NT; j++)
            step(1'b1, (TAPS[NT-1-j] > 0) ? -2048 : 2047, j == 0, 2047, "sat_pos");
        step(1'b1, 0, 1'b1, -2048, "sat_neg");

        repeat (3) @(negedge clk);
        n_total++;
        if (exp_q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL scoreboard_drain: pending=%0d required=0", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
